// File: rtl/weight_pack_sequencer_pkg.sv
// Shared BitBlade weight-path constants, FSM state encoding and tile type.
package bitblade_pkg;

  localparam int unsigned NUM_WORDS = 16;
  localparam int unsigned SLICE_W   = 2;
  localparam int unsigned WORD_W    = NUM_WORDS * SLICE_W;
  localparam int unsigned IDX_W     = $clog2(NUM_WORDS);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] tile_t;

endpackage

// File: rtl/weight_pack_sequencer_if.sv
// Fetch-side and PE-side valid/ready streams of the weight pack sequencer.
interface weight_pack_sequencer_if;
  import bitblade_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/weight_pack_sequencer_transpose.sv
// Combinational tile transpose: slice j of word i becomes slice i of packed word j.
module weight_slice_transpose
  import bitblade_pkg::*;
(
  input  tile_t i_tile,
  output tile_t o_packed
);

  always_comb begin
    o_packed = '0;
    for (int unsigned j = 0; j < NUM_WORDS; j++) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        o_packed[j][SLICE_W*i +: SLICE_W] = i_tile[i][SLICE_W*j +: SLICE_W];
      end
    end
  end

endmodule

// File: rtl/weight_pack_sequencer.sv
// Collects a 16-word weight tile, then streams its 16 transposed 2-bit slice words.
module weight_pack_sequencer
  import bitblade_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    abort,
  weight_pack_sequencer_if.slave  bus,
  output logic                    tile_done,
  output logic [15:0]             tile_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_e           r_state;
  logic [IDX_W-1:0] r_wr_ptr;
  logic [IDX_W-1:0] r_rd_ptr;
  tile_t            r_buf;
  logic             r_tile_done;
  logic [15:0]      r_tile_count;

  tile_t            w_packed;
  logic             w_in_fire;
  logic             w_out_fire;

  weight_slice_transpose u_transpose (
    .i_tile   (r_buf),
    .o_packed (w_packed)
  );

  // Ready/valid come from state alone so neither side sees a combinational loop.
  assign w_in_fire  = bus.in_valid  && (r_state == FILL);
  assign w_out_fire = bus.out_ready && (r_state == DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= FILL;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_buf        <= '0;
      r_tile_done  <= 1'b0;
      r_tile_count <= '0;
    end else if (abort) begin
      r_state     <= FILL;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_tile_done <= 1'b0;
    end else begin
      r_tile_done <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_in_fire) begin
            r_buf[r_wr_ptr] <= bus.in_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
            if (r_wr_ptr == LAST_IDX) begin
              r_state  <= DRAIN;
              r_wr_ptr <= '0;
              r_rd_ptr <= '0;
            end
          end
        end
        DRAIN: begin
          if (w_out_fire) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_rd_ptr == LAST_IDX) begin
              r_state      <= FILL;
              r_rd_ptr     <= '0;
              r_tile_done  <= 1'b1;
              r_tile_count <= r_tile_count + 1'b1;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == FILL);
  assign bus.out_valid = (r_state == DRAIN);
  assign bus.out_data  = w_packed[r_rd_ptr];
  assign bus.out_idx   = r_rd_ptr;
  assign bus.out_last  = (r_state == DRAIN) && (r_rd_ptr == LAST_IDX);
  assign tile_done     = r_tile_done;
  assign tile_count    = r_tile_count;

endmodule
